// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_REFUND = 2'd2
  } statetype;

  // Coin values in units of 5 cents.
  localparam int COIN_N = 1;
  localparam int COIN_D = 2;
  localparam int COIN_Q = 5;

endpackage

// File: rtl/coin_value.sv
// Combinational coin decode: unit value of a single coin, plus a flag
// when more than one strobe is high in the same cycle.
module coin_value
  import vend_pkg::*;
(
  input  logic       coin_n,
  input  logic       coin_d,
  input  logic       coin_q,
  output logic [2:0] value,
  output logic       any,
  output logic       illegal
);

  // Value is forced to zero on a multi-coin cycle so it can never be added.
  always_comb begin
    value   = 3'd0;
    any     = coin_n | coin_d | coin_q;
    illegal = (coin_n & coin_d) | (coin_n & coin_q) | (coin_d & coin_q);
    if (!illegal) begin
      if (coin_n) value = 3'(COIN_N);
      if (coin_d) value = 3'(COIN_D);
      if (coin_q) value = 3'(COIN_Q);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Moore vending controller: accumulates coins, vends with change once the
// price is reached, refunds on cancel, and flags rejected coins a cycle later.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE = 5,
  parameter int W     = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         coin_n,
  input  logic         coin_d,
  input  logic         coin_q,
  input  logic         cancel,
  output logic [W-1:0] sum,
  output logic         dispense,
  output logic         refund,
  output logic [W-1:0] change,
  output logic         change_valid,
  output logic         reject
);

  // Largest reachable total is (PRICE-1) + quarter = PRICE+4.
  if (2**W <= PRICE + 4) begin : g_width_chk
    $error("vend_ctrl: W too narrow to hold PRICE+4");
  end

  statetype     state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic         reject_q, reject_d;

  logic [2:0]   coin_val;
  logic         coin_any;
  logic         coin_ill;

  coin_value u_coin_value (
    .coin_n  (coin_n),
    .coin_d  (coin_d),
    .coin_q  (coin_q),
    .value   (coin_val),
    .any     (coin_any),
    .illegal (coin_ill)
  );

  // State, sum and reject registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      reject_q <= reject_d;
    end
  end

  // Next state: cancel beats coins; coins outside S_IDLE are dropped.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          reject_d = coin_any;
          if (sum_q != '0) state_d = S_REFUND;
        end else if (coin_any) begin
          if (coin_ill) begin
            reject_d = 1'b1;
          end else begin
            sum_d = sum_q + W'(coin_val);
            if (sum_d >= W'(PRICE)) state_d = S_VEND;
          end
        end
      end
      S_VEND, S_REFUND: begin
        state_d  = S_IDLE;
        sum_d    = '0;
        reject_d = coin_any;
      end
      default: begin
        state_d = S_IDLE;
        sum_d   = '0;
      end
    endcase
  end

  // Output decode from state and sum only.
  always_comb begin
    dispense     = 1'b0;
    refund       = 1'b0;
    change_valid = 1'b0;
    change       = '0;
    case (state_q)
      S_VEND: begin
        dispense     = 1'b1;
        change_valid = 1'b1;
        change       = sum_q - W'(PRICE);
      end
      S_REFUND: begin
        refund       = 1'b1;
        change_valid = 1'b1;
        change       = sum_q;
      end
      default: ;
    endcase
  end

  assign sum    = sum_q;
  assign reject = reject_q;

endmodule
